wdt_service_ctrl: RTL and testbench
===================================

Name: wdt_service_ctrl

Overview:
Hardware heartbeat aggregator that owns the register interface of the system watchdog timer (16-bit Avalon-MM slave; 5,000,000-cycle timeout, non-stoppable once started). It arms the watchdog, then services it only when every enabled software task has checked in within each service window. A missed window withholds the kick, and the watchdog then asserts its reset request. It sits between the CPU-side task heartbeat strobes and the watchdog slave port, as that port's only master.

Parameters:
NUM_TASKS, 4, number of heartbeat inputs (1..16)
KICK_INTERVAL, 2500000, service window length in clk cycles; must be < 5000000 and >= 4
IRQ_ON_ARM, 0, value written to control bit 0 (watchdog irq enable) at arm

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous, active-low reset
enable  input  1  level; request to arm the watchdog, sampled only in IDLE
heartbeat  input  NUM_TASKS  one-cycle check-in pulses, one per task
task_mask  input  NUM_TASKS  1 = task must check in each window; sampled at window end
wd_address  output  3  watchdog slave address
wd_chipselect  output  1  watchdog slave select
wd_write_n  output  1  watchdog write strobe, active-low
wd_writedata  output  16  watchdog write data
armed  output  1  watchdog has been started
fault  output  1  a window was missed; kicking has stopped permanently
missed_task  output  NUM_TASKS  enabled tasks absent in the failing window

Behaviour:
- Reset (async, any state): FSM = IDLE. wd_chipselect=0, wd_write_n=1, wd_address=0, wd_writedata=0. armed=0, fault=0, missed_task=0, sticky heartbeats=0, window counter=0.
- All bus outputs are registered. A write is exactly one cycle with chipselect=1 and write_n=0; the slave accepts it with no wait states. The block never issues reads and never drives back-to-back writes.
- Idle bus state: chipselect=0, write_n=1, address=0, data=0.
- FSM states: IDLE, CLR, ARM, RUN, KICK, FAULT.
- IDLE -> ARM on enable=1. The ARM write is driven in the next cycle: address 1, data 16'h0004 | IRQ_ON_ARM (bit 2 = start).
- ARM -> RUN after 1 cycle. On that edge: armed=1, counter loads KICK_INTERVAL-1, sticky bits clear.
- RUN: counter decrements each cycle. At counter==0 it reloads KICK_INTERVAL-1, so windows are exactly KICK_INTERVAL cycles long, and the window is evaluated.
- Evaluation: pass if (sticky | heartbeat) & task_mask == task_mask; a heartbeat in the evaluation cycle counts for the ending window.
  - Pass: sticky clears and -> KICK.
  - Fail: missed_task = task_mask & ~(sticky | heartbeat), fault=1, -> FAULT.
- KICK: 1 cycle, write address 2, data 16'h0000 (period write = force reload). Then -> RUN. The counter keeps running through KICK.
- Sticky bits set on heartbeat in RUN and KICK. Heartbeats in IDLE, CLR, ARM and FAULT are ignored.
- task_mask all zero: every window passes, so the watchdog is kicked unconditionally.
- enable deasserted after arming is ignored. The watchdog cannot be stopped, so armed stays 1 until reset_n.
- FAULT: terminal. No further bus writes. fault and missed_task are held until reset_n.
- Kick-to-kick spacing is exactly KICK_INTERVAL cycles. The first kick lands KICK_INTERVAL+1 cycles after the ARM write.

Optional Feature:
Macro WDT_SERVICE_CLR_EN.
- Defined: IDLE -> CLR on enable=1. CLR writes address 0, data 16'h0000 (clears a stale timeout flag), then -> ARM. The ARM write therefore follows the CLR write with exactly one cycle between them.
- Undefined: CLR state and its logic are absent; IDLE -> ARM directly.

Test Plan:
- KICK_INTERVAL=16, NUM_TASKS=4, mask=4'hF. Assert enable after reset -> one write addr1 data 16'h0004 in the cycle after enable is seen; armed=1 the following cycle.
- All four tasks pulse once per window -> addr2 data 0 write every 16 cycles; first kick 17 cycles after the ARM write; fault stays 0 for 10 windows.
- Task 2 silent in window 3 -> no kick at end of window 3; fault=1, missed_task=4'b0100; no further writes; 5,000,000 cycles later the watchdog resetrequest rises.
- Task 1 pulses in the exact evaluation cycle -> window passes and the kick is issued; the same pulse does not count toward the next window.
- mask=4'h0, no heartbeats -> kick every 16 cycles. Drop enable mid-run -> kicks continue, armed=1. Assert reset_n low mid-KICK -> bus idle asynchronously, state IDLE.
- WDT_SERVICE_CLR_EN defined -> addr0 data 0 write, then the addr1 data 16'h0004 write two cycles later. IRQ_ON_ARM=1 -> arm data 16'h0005.

Source files
------------

// File: rtl/wdt_service_ctrl.sv
// Heartbeat aggregator that arms the system watchdog and kicks it only when every enabled task checked in.
// Optional macro WDT_SERVICE_CLR_EN: clear the watchdog status register before arming.
module wdt_service_ctrl #(
  parameter int unsigned NUM_TASKS     = 4,
  parameter int unsigned KICK_INTERVAL = 2500000,
  parameter int unsigned IRQ_ON_ARM    = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic [NUM_TASKS-1:0] heartbeat,
  input  logic [NUM_TASKS-1:0] task_mask,
  output logic [2:0]           wd_address,
  output logic                 wd_chipselect,
  output logic                 wd_write_n,
  output logic [15:0]          wd_writedata,
  output logic                 armed,
  output logic                 fault,
  output logic [NUM_TASKS-1:0] missed_task
);

  localparam int unsigned CNT_W        = $clog2(KICK_INTERVAL);
  localparam logic [CNT_W-1:0] RELOAD  = CNT_W'(KICK_INTERVAL - 1);
  localparam logic [15:0] ARM_DATA     = (IRQ_ON_ARM != 0) ? 16'h0005 : 16'h0004;
  localparam logic [15:0] PERIOD_DATA  = 16'h0000;
  localparam logic [2:0]  ADDR_CONTROL = 3'd1;
  localparam logic [2:0]  ADDR_PERIOD  = 3'd2;
`ifdef WDT_SERVICE_CLR_EN
  localparam logic [2:0]  ADDR_STATUS  = 3'd0;
  localparam logic [15:0] STATUS_DATA  = 16'h0000;
`endif

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
`ifdef WDT_SERVICE_CLR_EN
    CLR   = 3'd1,
`endif
    ARM   = 3'd2,
    RUN   = 3'd3,
    KICK  = 3'd4,
    FAULT = 3'd5
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     count;
  logic [NUM_TASKS-1:0] sticky;
`ifdef WDT_SERVICE_CLR_EN
  logic                 clr_gap;
`endif

  // A heartbeat in the evaluation cycle still counts for the ending window.
  logic [NUM_TASKS-1:0] seen_c;
  logic                 window_end_c;
  logic                 window_pass_c;

  assign seen_c        = sticky | heartbeat;
  assign window_end_c  = (count == '0);
  assign window_pass_c = ((seen_c & task_mask) == task_mask);

  // Sequencer: bus strobes default to idle every cycle so each write lasts exactly one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      count         <= '0;
      sticky        <= '0;
      armed         <= 1'b0;
      fault         <= 1'b0;
      missed_task   <= '0;
      wd_chipselect <= 1'b0;
      wd_write_n    <= 1'b1;
      wd_address    <= '0;
      wd_writedata  <= '0;
`ifdef WDT_SERVICE_CLR_EN
      clr_gap       <= 1'b0;
`endif
    end else begin
      wd_chipselect <= 1'b0;
      wd_write_n    <= 1'b1;
      wd_address    <= '0;
      wd_writedata  <= '0;

      case (state)
        IDLE: begin
          if (enable) begin
`ifdef WDT_SERVICE_CLR_EN
            state         <= CLR;
            clr_gap       <= 1'b0;
            wd_chipselect <= 1'b1;
            wd_write_n    <= 1'b0;
            wd_address    <= ADDR_STATUS;
            wd_writedata  <= STATUS_DATA;
`else
            state         <= ARM;
            wd_chipselect <= 1'b1;
            wd_write_n    <= 1'b0;
            wd_address    <= ADDR_CONTROL;
            wd_writedata  <= ARM_DATA;
`endif
          end
        end

`ifdef WDT_SERVICE_CLR_EN
        // One idle bus cycle separates the status clear from the arm write.
        CLR: begin
          if (clr_gap) begin
            state         <= ARM;
            wd_chipselect <= 1'b1;
            wd_write_n    <= 1'b0;
            wd_address    <= ADDR_CONTROL;
            wd_writedata  <= ARM_DATA;
          end else begin
            clr_gap <= 1'b1;
          end
        end
`endif

        ARM: begin
          state  <= RUN;
          armed  <= 1'b1;
          count  <= RELOAD;
          sticky <= '0;
        end

        // The window counter keeps running through the kick cycle.
        RUN, KICK: begin
          if (window_end_c) begin
            count <= RELOAD;
            if (window_pass_c) begin
              state         <= KICK;
              sticky        <= '0;
              wd_chipselect <= 1'b1;
              wd_write_n    <= 1'b0;
              wd_address    <= ADDR_PERIOD;
              wd_writedata  <= PERIOD_DATA;
            end else begin
              state       <= FAULT;
              fault       <= 1'b1;
              missed_task <= task_mask & ~seen_c;
            end
          end else begin
            count  <= count - CNT_W'(1);
            sticky <= seen_c;
            if (state == KICK) begin
              state <= RUN;
            end
          end
        end

        // Terminal: the watchdog times out and requests reset.
        FAULT: ;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wdt_service_ctrl.sv
// Directed bench for wdt_service_ctrl: expected bus writes are queued with their cycle and checked by a bus monitor.
module tb_wdt_service_ctrl;

  localparam int unsigned NT  = 4;
  localparam int unsigned KI  = 16;
  localparam int unsigned IRQ = 1;
  localparam logic [15:0] ARM_DATA = (IRQ != 0) ? 16'h0005 : 16'h0004;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic [NT-1:0] heartbeat = '0;
  logic [NT-1:0] task_mask = 4'hF;
  logic [2:0]    wd_address;
  logic          wd_chipselect;
  logic          wd_write_n;
  logic [15:0]   wd_writedata;
  logic          armed;
  logic          fault;
  logic [NT-1:0] missed_task;

  wdt_service_ctrl #(
    .NUM_TASKS    (NT),
    .KICK_INTERVAL(KI),
    .IRQ_ON_ARM   (IRQ)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .heartbeat    (heartbeat),
    .task_mask    (task_mask),
    .wd_address   (wd_address),
    .wd_chipselect(wd_chipselect),
    .wd_write_n   (wd_write_n),
    .wd_writedata (wd_writedata),
    .armed        (armed),
    .fault        (fault),
    .missed_task  (missed_task)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    int          cyc;
    logic [2:0]  addr;
    logic [15:0] data;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   last_wr = -10;

  // Bus monitor: every observed write must match the head of the expectation queue.
  always @(negedge clk) begin
    if (wd_chipselect !== 1'b0 || wd_write_n !== 1'b1) begin
      n_vec++;
      assert (q.size() != 0) else begin
        n_err++;
        $error("FAIL unexpected_write cyc=%0d got addr=%0d data=%h expected no write", cyc, wd_address, wd_writedata);
      end
      if (q.size() != 0) begin
        mon_e = q.pop_front();
        n_vec++;
        assert ({wd_chipselect, wd_write_n, wd_address, wd_writedata, cyc} ===
                {1'b1, 1'b0, mon_e.addr, mon_e.data, mon_e.cyc}) else begin
          n_err++;
          $error("FAIL bus_write got cs=%b wn=%b addr=%0d data=%h cyc=%0d expected cs=1 wn=0 addr=%0d data=%h cyc=%0d",
                 wd_chipselect, wd_write_n, wd_address, wd_writedata, cyc, mon_e.addr, mon_e.data, mon_e.cyc);
        end
      end
      n_vec++;
      assert (cyc != last_wr + 1) else begin
        n_err++;
        $error("FAIL back_to_back got writes at cyc=%0d and cyc=%0d expected a gap", last_wr, cyc);
      end
      last_wr = cyc;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout got no finish expected completion");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_exp(input int c, input logic [2:0] a, input logic [15:0] d);
    exp_t e;
    e.cyc  = c;
    e.addr = a;
    e.data = d;
    q.push_back(e);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_bus"}, {11'd0, wd_chipselect, wd_write_n, wd_address, wd_writedata}, {11'd0, 1'b0, 1'b1, 3'd0, 16'h0});
    chk({tag, "_armed"}, 32'(armed), 32'd0);
    chk({tag, "_fault"}, 32'(fault), 32'd0);
    chk({tag, "_missed"}, 32'(missed_task), 32'd0);
  endtask

  task automatic do_reset();
    chk("pending_writes", 32'(q.size()), 32'd0);
    q.delete();
    @(posedge clk);
    #1;
    reset_n   = 1'b0;
    enable    = 1'b0;
    heartbeat = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk_idle("after_reset");
  endtask

  // Raise enable and queue the arm sequence; returns the cycle of the arm write.
  task automatic start_wdt(output int a);
    int k;
    @(posedge clk);
    #1;
    enable = 1'b1;
    k = cyc;
`ifdef WDT_SERVICE_CLR_EN
    push_exp(k + 1, 3'd0, 16'h0000);
    a = k + 3;
`else
    a = k + 1;
`endif
    push_exp(a, 3'd1, ARM_DATA);
    wait_cyc(a);
    chk("armed_during_arm", 32'(armed), 32'd0);
    wait_cyc(a + 1);
    chk("armed_after_arm", 32'(armed), 32'd1);
  endtask

  // Drive one window: early tasks pulse at staggered offsets, late tasks in the evaluation cycle.
  task automatic run_window(input int a, input int w, input logic [NT-1:0] early, input logic [NT-1:0] late);
    for (int off = 0; off < int'(KI); off++) begin
      logic [NT-1:0] hb;
      hb = '0;
      for (int i = 0; i < int'(NT); i++) begin
        if (early[i] && ((i * 3 + w) % 15) == off) hb[i] = 1'b1;
      end
      if (off == int'(KI) - 1) hb = hb | late;
      wait_cyc(a + 1 + int'(KI) * w + off);
      heartbeat = hb;
    end
    wait_cyc(a + int'(KI) * (w + 1) + 1);
    heartbeat = '0;
  endtask

  initial begin
    int a;

    repeat (2) @(posedge clk);
    #1;
    chk_idle("in_reset");
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk_idle("idle_no_enable");

    // Ten passing windows, task 1 checks in only in the evaluation cycle of window 4.
    task_mask = 4'hF;
    start_wdt(a);
    for (int w = 0; w < 10; w++) begin
      push_exp(a + int'(KI) + 1 + int'(KI) * w, 3'd2, 16'h0000);
      if (w == 4) run_window(a, w, 4'b1101, 4'b0010);
      else        run_window(a, w, 4'hF, 4'h0);
    end
    wait_cyc(a + int'(KI) * 10 + 2);
    chk("pass_fault", 32'(fault), 32'd0);
    chk("pass_missed", 32'(missed_task), 32'd0);
    chk("pass_armed", 32'(armed), 32'd1);

    // Task 2 silent in window 3: no kick, fault latched, no further writes.
    do_reset();
    start_wdt(a);
    for (int w = 0; w < 3; w++) begin
      push_exp(a + int'(KI) + 1 + int'(KI) * w, 3'd2, 16'h0000);
      run_window(a, w, 4'hF, 4'h0);
    end
    run_window(a, 3, 4'b1011, 4'h0);
    chk("miss_fault", 32'(fault), 32'd1);
    chk("miss_task", 32'(missed_task), 32'h4);
    run_window(a, 4, 4'hF, 4'hF);
    run_window(a, 5, 4'hF, 4'h0);
    chk("fault_held", 32'(fault), 32'd1);
    chk("missed_held", 32'(missed_task), 32'h4);
    chk("fault_armed", 32'(armed), 32'd1);

    // An evaluation-cycle pulse does not carry into the next window.
    do_reset();
    start_wdt(a);
    push_exp(a + int'(KI) + 1, 3'd2, 16'h0000);
    run_window(a, 0, 4'b1101, 4'b0010);
    run_window(a, 1, 4'b1101, 4'h0);
    chk("nocarry_fault", 32'(fault), 32'd1);
    chk("nocarry_missed", 32'(missed_task), 32'h2);

    // Empty mask: unconditional kicks, enable drop ignored, reset mid-kick.
    do_reset();
    task_mask = 4'h0;
    start_wdt(a);
    for (int w = 0; w < 4; w++) begin
      push_exp(a + int'(KI) + 1 + int'(KI) * w, 3'd2, 16'h0000);
      if (w == 1) enable = 1'b0;
      run_window(a, w, 4'h0, 4'h0);
    end
    wait_cyc(a + int'(KI) * 5 + 1);
    chk("kick_before_reset", {wd_chipselect, wd_write_n, wd_address}, {1'b1, 1'b0, 3'd2});
    chk("armed_after_enable_drop", 32'(armed), 32'd1);
    reset_n = 1'b0;
    #1;
    chk_idle("async_reset_mid_kick");
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    wait_cyc(cyc + 40);
    chk("idle_after_reset_armed", 32'(armed), 32'd0);
    chk("final_pending_writes", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
